// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA cell bank: opcode encodings and the
// per-slot write command issued by the bank to each cell.
package esfa_pkg;

  localparam logic [3:0] OP_UPDATE     = 4'd0;
  localparam logic [3:0] OP_LOOKUP     = 4'd1;
  localparam logic [3:0] OP_ENCODE     = 4'd2;
  localparam logic [3:0] OP_ALLOC      = 4'd3;
  localparam logic [3:0] OP_FREE       = 4'd4;
  localparam logic [3:0] OP_MARK_AVAIL = 4'd5;
  localparam logic [3:0] OP_ENRANK     = 4'd6;
  localparam logic [3:0] OP_RANGE      = 4'd7;

  // Write applied to one cell on the accept edge; WR_NONE leaves it untouched.
  typedef enum logic [2:0] {
    WR_NONE   = 3'd0,
    WR_ALLOC  = 3'd1,
    WR_UPDATE = 3'd2,
    WR_CLEAR  = 3'd3,
    WR_ENRANK = 3'd4
  } wr_op_e;

endpackage

// File: rtl/esfa_cell_slot.sv
// One ESFA cell: holds the cell state, reports its match flags against the
// current command and applies the write the bank selects for it.
module esfa_cell_slot
  import esfa_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  wr_op_e       wr_op_i,
  input  logic [W-1:0] handle_i,
  input  logic [W-1:0] index_i,
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] meta_i,
  output logic         amatch_o,
  output logic         ematch_o,
  output logic         vacant_o,
  output logic [W-1:0] value_o,
  output logic [W-1:0] rank_o,
  output logic [W-1:0] low_o,
  output logic [W-1:0] high_o
);

  logic         arr_def_q, arr_def_d;
  logic         elt_def_q, elt_def_d;
  logic [W-1:0] array_code_q, array_code_d;
  logic [W-1:0] rank_q, rank_d;
  logic [W-1:0] low_q, low_d;
  logic [W-1:0] high_q, high_d;
  logic [W-1:0] index_q, index_d;
  logic [W-1:0] value_q, value_d;

  assign amatch_o = arr_def_q && (array_code_q == handle_i);
  assign ematch_o = amatch_o && elt_def_q && (index_q == index_i);
  assign vacant_o = !arr_def_q;
  assign value_o  = value_q;
  assign rank_o   = rank_q;
  assign low_o    = low_q;
  assign high_o   = high_q;

  always_comb begin
    arr_def_d    = arr_def_q;
    elt_def_d    = elt_def_q;
    array_code_d = array_code_q;
    rank_d       = rank_q;
    low_d        = low_q;
    high_d       = high_q;
    index_d      = index_q;
    value_d      = value_q;
    case (wr_op_i)
      WR_ALLOC: begin
        arr_def_d    = 1'b1;
        elt_def_d    = 1'b1;
        array_code_d = handle_i;
        rank_d       = meta_i;
        low_d        = index_i;
        high_d       = index_i;
        index_d      = index_i;
        value_d      = value_i;
      end
      WR_UPDATE: value_d = value_i;
      WR_CLEAR: begin
        arr_def_d    = 1'b0;
        elt_def_d    = 1'b0;
        array_code_d = '0;
        rank_d       = '0;
        low_d        = '0;
        high_d       = '0;
        index_d      = '0;
        value_d      = '0;
      end
      // Rank saturates: an all-ones rank is left alone.
      WR_ENRANK: if (rank_q != '1) rank_d = rank_q + W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_def_q    <= 1'b0;
      elt_def_q    <= 1'b0;
      array_code_q <= '0;
      rank_q       <= '0;
      low_q        <= '0;
      high_q       <= '0;
      index_q      <= '0;
      value_q      <= '0;
    end else begin
      arr_def_q    <= arr_def_d;
      elt_def_q    <= elt_def_d;
      array_code_q <= array_code_d;
      rank_q       <= rank_d;
      low_q        <= low_d;
      high_q       <= high_d;
      index_q      <= index_d;
      value_q      <= value_d;
    end
  end

endmodule

// File: rtl/esfa_cell_bank.sv
// Bank of DEPTH ESFA cells evaluated in parallel, with a one-entry registered
// response channel. Optional hit counter enabled by ESFA_CELL_HITCNT_EN.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// a response transfers where rsp_valid && rsp_ready. cmd_ready is
// !rsp_valid || rsp_ready, so an unconsumed response holds its fields stable
// and stalls the command side; consume and accept may share one edge.
module esfa_cell_bank
  import esfa_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
`ifdef ESFA_CELL_HITCNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_write,
  input  logic [W-1:0]     cmd_handle,
  input  logic [W-1:0]     cmd_index,
  input  logic [W-1:0]     cmd_value,
  input  logic [W-1:0]     cmd_meta,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_bool,
  output logic [W-1:0]     rsp_value,
  output logic [W-1:0]     rsp_context,
  output logic             rsp_err
`ifdef ESFA_CELL_HITCNT_EN
  , output logic [CNT_W-1:0] hit_count
`endif
);

  logic [DEPTH-1:0] amatch, ematch, vacant;
  logic [W-1:0]     slot_value [DEPTH];
  logic [W-1:0]     slot_rank  [DEPTH];
  logic [W-1:0]     slot_low   [DEPTH];
  logic [W-1:0]     slot_high  [DEPTH];
  wr_op_e           slot_wr    [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    esfa_cell_slot #(.W(W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_op_i  (slot_wr[g]),
      .handle_i (cmd_handle),
      .index_i  (cmd_index),
      .value_i  (cmd_value),
      .meta_i   (cmd_meta),
      .amatch_o (amatch[g]),
      .ematch_o (ematch[g]),
      .vacant_o (vacant[g]),
      .value_o  (slot_value[g]),
      .rank_o   (slot_rank[g]),
      .low_o    (slot_low[g]),
      .high_o   (slot_high[g])
    );
  end

  logic             accept, wr_en;
  logic             rsp_valid_q, rsp_bool_q, rsp_err_q;
  logic [W-1:0]     rsp_value_q, rsp_context_q;
  logic             rsp_bool_d, rsp_err_d;
  logic [W-1:0]     rsp_value_d, rsp_context_d;

  assign cmd_ready = !rsp_valid_q || rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign wr_en     = accept && cmd_write;

  // Priority encoders (lowest slot wins), popcounts and ENRANK maximum.
  logic [W-1:0]     hit_idx, hit_val, enc_idx, free_idx, rng_idx;
  logic [W-1:0]     a_cnt, free_cnt, enr_max;
  logic [DEPTH-1:0] hit_oh, free_oh;
  logic             rng_any, enr_any;

  always_comb begin
    hit_idx  = '0;
    hit_val  = '0;
    hit_oh   = '0;
    enc_idx  = '0;
    free_idx = '0;
    free_oh  = '0;
    rng_idx  = '0;
    rng_any  = 1'b0;
    a_cnt    = '0;
    free_cnt = '0;
    enr_any  = 1'b0;
    enr_max  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ematch[i]) begin
        hit_idx = W'(i);
        hit_val = slot_value[i];
        hit_oh  = '0;
        hit_oh[i] = 1'b1;
      end
      if (amatch[i]) enc_idx = W'(i);
      if (vacant[i]) begin
        free_idx = W'(i);
        free_oh  = '0;
        free_oh[i] = 1'b1;
      end
      if (amatch[i] && (slot_low[i] <= cmd_index) && (cmd_index <= slot_high[i])) begin
        rng_idx = W'(i);
        rng_any = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      a_cnt    = a_cnt + {{(W-1){1'b0}}, amatch[i]};
      free_cnt = free_cnt + {{(W-1){1'b0}}, vacant[i]};
      if (amatch[i] && (slot_rank[i] != '1)) begin
        enr_any = 1'b1;
        if ((slot_rank[i] + W'(1)) > enr_max) enr_max = slot_rank[i] + W'(1);
      end
    end
  end

  always_comb begin
    rsp_bool_d    = 1'b0;
    rsp_value_d   = '0;
    rsp_context_d = '0;
    rsp_err_d     = 1'b0;
    for (int i = 0; i < DEPTH; i++) slot_wr[i] = WR_NONE;
    case (cmd_op)
      OP_UPDATE: begin
        rsp_bool_d    = |ematch;
        rsp_value_d   = hit_val;
        rsp_context_d = hit_idx;
        for (int i = 0; i < DEPTH; i++)
          if (wr_en && hit_oh[i]) slot_wr[i] = WR_UPDATE;
      end
      OP_LOOKUP: begin
        rsp_bool_d    = |ematch;
        rsp_value_d   = hit_val;
        rsp_context_d = hit_idx;
      end
      OP_ENCODE: begin
        rsp_bool_d    = |amatch;
        rsp_value_d   = a_cnt;
        rsp_context_d = enc_idx;
      end
      OP_ALLOC: begin
        rsp_bool_d    = |vacant;
        rsp_context_d = free_idx;
        for (int i = 0; i < DEPTH; i++)
          if (wr_en && free_oh[i]) slot_wr[i] = WR_ALLOC;
      end
      OP_FREE: begin
        rsp_bool_d  = |amatch;
        rsp_value_d = a_cnt;
        for (int i = 0; i < DEPTH; i++)
          if (wr_en && amatch[i]) slot_wr[i] = WR_CLEAR;
      end
      OP_MARK_AVAIL: begin
        rsp_bool_d    = |vacant;
        rsp_value_d   = free_cnt;
        rsp_context_d = free_idx;
      end
      OP_ENRANK: begin
        rsp_bool_d  = enr_any;
        rsp_value_d = enr_max;
        for (int i = 0; i < DEPTH; i++)
          if (wr_en && amatch[i]) slot_wr[i] = WR_ENRANK;
      end
      OP_RANGE: begin
        rsp_bool_d    = rng_any;
        rsp_context_d = rng_idx;
      end
      default: rsp_err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_bool_q    <= 1'b0;
      rsp_value_q   <= '0;
      rsp_context_q <= '0;
      rsp_err_q     <= 1'b0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_bool_q    <= rsp_bool_d;
      rsp_value_q   <= rsp_value_d;
      rsp_context_q <= rsp_context_d;
      rsp_err_q     <= rsp_err_d;
    end else if (rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_bool    = rsp_bool_q;
  assign rsp_value   = rsp_value_q;
  assign rsp_context = rsp_context_q;
  assign rsp_err     = rsp_err_q;

`ifdef ESFA_CELL_HITCNT_EN
  logic [CNT_W-1:0] hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_q <= '0;
    else if (accept && rsp_bool_d && (hit_q != '1))
      hit_q <= hit_q + CNT_W'(1);
  end

  assign hit_count = hit_q;
`endif

endmodule

// File: tb/tb_esfa_cell_bank.sv
// Self-checking bench for esfa_cell_bank: directed vector table, a
// backpressure stream with an expected-response queue, and a mid-stream reset.
module tb_esfa_cell_bank;
  import esfa_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_handle, cmd_index, cmd_value, cmd_meta;
  logic         rsp_valid, rsp_ready, rsp_bool, rsp_err;
  logic [W-1:0] rsp_value, rsp_context;
`ifdef ESFA_CELL_HITCNT_EN
  logic [15:0]  hit_count;
`endif

  always #5 clk = ~clk;

  esfa_cell_bank #(.W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_write   (cmd_write),
    .cmd_handle  (cmd_handle),
    .cmd_index   (cmd_index),
    .cmd_value   (cmd_value),
    .cmd_meta    (cmd_meta),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_bool    (rsp_bool),
    .rsp_value   (rsp_value),
    .rsp_context (rsp_context),
    .rsp_err     (rsp_err)
`ifdef ESFA_CELL_HITCNT_EN
    , .hit_count (hit_count)
`endif
  );

  typedef struct {
    logic [3:0]   op;
    logic         wr;
    logic [W-1:0] h, i, v, m;
    logic         eb;
    logic [W-1:0] ev, ec;
    logic         ee;
  } vec_t;

  vec_t         vecs[$];
  vec_t         strm[$];
  logic [W-1:0] exp_q[$];
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic wr, input logic [W-1:0] h, i, v, m,
                              input logic eb, input logic [W-1:0] ev, ec, input logic ee);
    vec_t r;
    r.op = op; r.wr = wr; r.h = h; r.i = i; r.v = v; r.m = m;
    r.eb = eb; r.ev = ev; r.ec = ec; r.ee = ee;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    cmd_op = t.op; cmd_write = t.wr; cmd_handle = t.h;
    cmd_index = t.i; cmd_value = t.v; cmd_meta = t.m;
  endtask

  // One command with rsp_ready high; response checked 1 time unit after the edge.
  task automatic apply(input vec_t t, input int id);
    @(negedge clk);
    drive(t);
    cmd_valid = 1'b1;
    #2;
    check("cmd_ready", id, cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("rsp_valid", id, rsp_valid, 1);
    check("rsp_bool", id, rsp_bool, t.eb);
    check("rsp_value", id, rsp_value, t.ev);
    check("rsp_context", id, rsp_context, t.ec);
    check("rsp_err", id, rsp_err, t.ee);
  endtask

  initial begin
    int exp_hits;
    int k, cyc, xfers;
    logic acc, xfer;

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    drive(mk(4'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rsp_valid", 0, rsp_valid, 0);
    check("reset_rsp_bool", 0, rsp_bool, 0);
    check("reset_rsp_value", 0, rsp_value, 0);
    check("reset_cmd_ready", 0, cmd_ready, 1);

    //            op             wr    h      i      v      m      b     val    ctx    err
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h03, 8'h05, 8'h11, 8'h02, 1'b1, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_LOOKUP,     1'b0, 8'h03, 8'h05, 8'h00, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0));
    vecs.push_back(mk(OP_UPDATE,     1'b0, 8'h03, 8'h05, 8'h22, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0));
    vecs.push_back(mk(OP_LOOKUP,     1'b0, 8'h03, 8'h05, 8'h00, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0));
    vecs.push_back(mk(OP_UPDATE,     1'b1, 8'h03, 8'h05, 8'h22, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0));
    vecs.push_back(mk(OP_LOOKUP,     1'b0, 8'h03, 8'h05, 8'h00, 8'h00, 1'b1, 8'h22, 8'h00, 1'b0));
    vecs.push_back(mk(OP_MARK_AVAIL, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h07, 8'h01, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h04, 8'h06, 8'h33, 8'hFE, 1'b1, 8'h00, 8'h01, 1'b0));
    vecs.push_back(mk(OP_ENCODE,     1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0));
    vecs.push_back(mk(OP_ENRANK,     1'b1, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0));
    vecs.push_back(mk(OP_ENRANK,     1'b1, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_RANGE,      1'b0, 8'h04, 8'h06, 8'h00, 8'h00, 1'b1, 8'h00, 8'h01, 1'b0));
    vecs.push_back(mk(OP_RANGE,      1'b0, 8'h04, 8'h07, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h03, 8'h07, 8'h44, 8'h00, 1'b1, 8'h00, 8'h02, 1'b0));
    vecs.push_back(mk(OP_ENCODE,     1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 8'h00, 1'b0));
    vecs.push_back(mk(OP_FREE,       1'b1, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 8'h00, 1'b0));
    vecs.push_back(mk(OP_LOOKUP,     1'b0, 8'h03, 8'h05, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_MARK_AVAIL, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h07, 8'h00, 1'b0));
    vecs.push_back(mk(4'd9,          1'b1, 8'h03, 8'h05, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1));
    vecs.push_back(mk(OP_ENCODE,     1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h10, 8'h01, 8'h50, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h11, 8'h01, 8'h51, 8'h00, 1'b1, 8'h00, 8'h02, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h12, 8'h01, 8'h52, 8'h00, 1'b1, 8'h00, 8'h03, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h13, 8'h01, 8'h53, 8'h00, 1'b1, 8'h00, 8'h04, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h14, 8'h01, 8'h54, 8'h00, 1'b1, 8'h00, 8'h05, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h15, 8'h01, 8'h55, 8'h00, 1'b1, 8'h00, 8'h06, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h16, 8'h01, 8'h56, 8'h00, 1'b1, 8'h00, 8'h07, 1'b0));
    vecs.push_back(mk(OP_ALLOC,      1'b1, 8'h20, 8'h00, 8'h99, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_MARK_AVAIL, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(OP_LOOKUP,     1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(4'd15,         1'b1, 8'h16, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1));
    vecs.push_back(mk(OP_LOOKUP,     1'b0, 8'h04, 8'h06, 8'h00, 8'h00, 1'b1, 8'h33, 8'h01, 1'b0));

    exp_hits = 0;
    foreach (vecs[n]) begin
      apply(vecs[n], n);
      if (vecs[n].eb) exp_hits++;
    end
`ifdef ESFA_CELL_HITCNT_EN
    check("hit_count", 0, hit_count, exp_hits);
`endif

    // Backpressure: 3 stalled cycles with a command waiting, then streaming.
    strm.push_back(mk(OP_LOOKUP, 1'b0, 8'h04, 8'h06, 8'h00, 8'h00, 1'b1, 8'h33, 8'h01, 1'b0));
    strm.push_back(mk(OP_LOOKUP, 1'b0, 8'h10, 8'h01, 8'h00, 8'h00, 1'b1, 8'h50, 8'h00, 1'b0));
    strm.push_back(mk(OP_LOOKUP, 1'b0, 8'h16, 8'h01, 8'h00, 8'h00, 1'b1, 8'h56, 8'h07, 1'b0));
    strm.push_back(mk(OP_ENCODE, 1'b0, 8'h12, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 8'h03, 1'b0));
    strm.push_back(mk(OP_LOOKUP, 1'b0, 8'h13, 8'h01, 8'h00, 8'h00, 1'b1, 8'h53, 8'h04, 1'b0));
    exp_q.push_back(8'h33);
    k = 0; cyc = 0; xfers = 0;
    while ((k < strm.size() || exp_q.size() > 0) && cyc < 40) begin
      @(negedge clk);
      rsp_ready = (cyc >= 3);
      cmd_valid = (k < strm.size());
      if (k < strm.size()) drive(strm[k]);
      #2;
      acc  = cmd_valid && cmd_ready;
      xfer = rsp_valid && rsp_ready;
      if (cyc < 3) begin
        check("stall_ready", cyc, cmd_ready, 0);
        check("stall_valid", cyc, rsp_valid, 1);
        check("stall_value", cyc, rsp_value, 8'h33);
      end
      if (xfer) begin
        xfers++;
        if (exp_q.size() > 0) check("stream_value", xfers, rsp_value, exp_q.pop_front());
        else check("stream_extra", xfers, 1, 0);
      end
      if (acc) begin
        exp_q.push_back(strm[k].ev);
        k++;
      end
      @(posedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    check("stream_issued", 0, k, strm.size());
    check("stream_drained", 0, exp_q.size(), 0);
    check("stream_xfers", 0, xfers, strm.size() + 1);

    // Asynchronous reset while a response is held.
    apply(mk(OP_LOOKUP, 1'b0, 8'h04, 8'h06, 8'h00, 8'h00, 1'b1, 8'h33, 8'h01, 1'b0), 100);
    rsp_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 0, rsp_valid, 0);
    check("arst_rsp_bool", 0, rsp_bool, 0);
    check("arst_rsp_value", 0, rsp_value, 0);
    check("arst_rsp_context", 0, rsp_context, 0);
    check("arst_rsp_err", 0, rsp_err, 0);
`ifdef ESFA_CELL_HITCNT_EN
    check("arst_hit_count", 0, hit_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    apply(mk(OP_LOOKUP,     1'b0, 8'h04, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0), 200);
    apply(mk(OP_MARK_AVAIL, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h08, 8'h00, 1'b0), 201);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
